// File: rtl/hazard_scheduler.sv
// Decode-stage stall/flush controller: per-register pending-write scoreboard
// plus EX occupancy tracking for multi-cycle ops.
module hazard_scheduler #(
  parameter int N       = 3,
  parameter int CNT_W   = 2,
  parameter int MUL_CYC = 3,
  parameter int SC_W    = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            d_valid,
  input  logic [N-1:0]    d_src,
  input  logic [N-1:0]    d_dst,
  input  logic            d_use_src,
  input  logic            d_use_dst,
  input  logic            d_reg_write,
  input  logic            d_multi,
  input  logic            wb_reg_write,
  input  logic [N-1:0]    wb_dst,
  input  logic            ex_flush,
  output logic            pc_en,
  output logic            fd_en,
  output logic            fd_flush,
  output logic            de_bubble,
  output logic            issue,
  output logic            stall,
  output logic            ex_busy,
  output logic [1:0]      state,
  output logic [SC_W-1:0] stall_cycles
);

  localparam int NREG = 2 ** N;
  localparam int BW   = (MUL_CYC > 1) ? $clog2(MUL_CYC) : 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_RAW   = 2'd1,
    ST_BUSY  = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  state_t            state_reg;
  logic [BW-1:0]     busy_cnt_reg;
  logic [SC_W-1:0]   stall_cycles_reg;
  logic [NREG-1:0]   pend_nz;
  logic [NREG-1:0]   pend_full;
  logic              raw;

  // One pending-write counter per architectural register.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_pend
    localparam logic [N-1:0] IDX = N'(gi);
    logic [CNT_W-1:0] cnt_reg;
    logic             inc;
    logic             dec;

    assign inc = issue & d_reg_write & (d_dst == IDX);
    assign dec = wb_reg_write & (wb_dst == IDX) & (cnt_reg != '0);
    assign pend_nz[gi]   = (cnt_reg != '0);
    assign pend_full[gi] = (cnt_reg == '1);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_reg <= '0;
      end else if (inc && !dec) begin
        cnt_reg <= cnt_reg + 1'b1;
      end else if (dec && !inc) begin
        cnt_reg <= cnt_reg - 1'b1;
      end
    end
  end

  // The full-counter term keeps a further writer from wrapping its counter.
  assign raw = d_valid & ((d_use_src & pend_nz[d_src]) |
                          (d_use_dst & pend_nz[d_dst]) |
                          (d_reg_write & pend_full[d_dst]));

  assign ex_busy      = (busy_cnt_reg != '0);
  assign issue        = d_valid & ~raw & ~ex_busy & ~ex_flush;
  assign stall        = d_valid & ~issue & ~ex_flush;
  assign pc_en        = ~stall;
  assign fd_en        = ~stall;
  assign fd_flush     = ex_flush;
  assign de_bubble    = ~issue;
  assign state        = state_reg;
  assign stall_cycles = stall_cycles_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_cnt_reg     <= '0;
      state_reg        <= ST_RUN;
      stall_cycles_reg <= '0;
    end else begin
      if (issue && d_multi) begin
        busy_cnt_reg <= BW'(MUL_CYC - 1);
      end else if (busy_cnt_reg != '0) begin
        busy_cnt_reg <= busy_cnt_reg - 1'b1;
      end

      if (ex_flush) begin
        state_reg <= ST_FLUSH;
      end else if (d_valid && raw) begin
        state_reg <= ST_RAW;
      end else if (d_valid && ex_busy) begin
        state_reg <= ST_BUSY;
      end else begin
        state_reg <= ST_RUN;
      end

      if (stall && (stall_cycles_reg != '1)) begin
        stall_cycles_reg <= stall_cycles_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Scoreboard bench for hazard_scheduler: directed cycles push expected outputs,
// a negedge monitor pops and compares.
module tb_hazard_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        d_valid;
  logic [2:0]  d_src;
  logic [2:0]  d_dst;
  logic        d_use_src;
  logic        d_use_dst;
  logic        d_reg_write;
  logic        d_multi;
  logic        wb_reg_write;
  logic [2:0]  wb_dst;
  logic        ex_flush;
  logic        pc_en;
  logic        fd_en;
  logic        fd_flush;
  logic        de_bubble;
  logic        issue;
  logic        stall;
  logic        ex_busy;
  logic [1:0]  state;
  logic [15:0] stall_cycles;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [8:0]  ctl;
    logic [15:0] sc;
  } exp_t;

  exp_t exp_q[$];

  hazard_scheduler #(.N(3), .CNT_W(2), .MUL_CYC(3), .SC_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .d_valid      (d_valid),
    .d_src        (d_src),
    .d_dst        (d_dst),
    .d_use_src    (d_use_src),
    .d_use_dst    (d_use_dst),
    .d_reg_write  (d_reg_write),
    .d_multi      (d_multi),
    .wb_reg_write (wb_reg_write),
    .wb_dst       (wb_dst),
    .ex_flush     (ex_flush),
    .pc_en        (pc_en),
    .fd_en        (fd_en),
    .fd_flush     (fd_flush),
    .de_bubble    (de_bubble),
    .issue        (issue),
    .stall        (stall),
    .ex_busy      (ex_busy),
    .state        (state),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  // Monitor: control bits are {pc_en, fd_en, fd_flush, de_bubble, issue, stall, ex_busy, state}.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t       e;
      logic [8:0] act;
      e   = exp_q.pop_front();
      act = {pc_en, fd_en, fd_flush, de_bubble, issue, stall, ex_busy, state};
      total++;
      if (act !== e.ctl || stall_cycles !== e.sc) begin
        bad++;
        $display("FAIL %s: ctl actual=%b required=%b stall_cycles actual=%0d required=%0d",
                 e.name, act, e.ctl, stall_cycles, e.sc);
      end else begin
        $display("txn %s: ctl=%b stall_cycles=%0d ok", e.name, act, stall_cycles);
      end
    end
  end

  task automatic drive(input logic v, input logic [2:0] src, input logic [2:0] dst,
                       input logic us, input logic ud, input logic rw, input logic mu,
                       input logic wbw, input logic [2:0] wbd, input logic fl);
    d_valid      = v;
    d_src        = src;
    d_dst        = dst;
    d_use_src    = us;
    d_use_dst    = ud;
    d_reg_write  = rw;
    d_multi      = mu;
    wb_reg_write = wbw;
    wb_dst       = wbd;
    ex_flush     = fl;
  endtask

  // Expected control vector: pc_en/fd_en follow ~stall, fd_flush follows the
  // driven ex_flush, de_bubble is ~issue.
  task automatic expect_out(input string nm, input logic iss, input logic stl,
                            input logic busy, input logic [1:0] st, input logic [15:0] sc);
    exp_t e;
    e.name = nm;
    e.ctl  = {~stl, ~stl, ex_flush, ~iss, iss, stl, busy, st};
    e.sc   = sc;
    exp_q.push_back(e);
  endtask

  // One cycle: inputs applied 1 time unit after the rising edge.
  task automatic step(input string nm, input logic v, input logic [2:0] src,
                      input logic [2:0] dst, input logic us, input logic ud,
                      input logic rw, input logic mu, input logic wbw,
                      input logic [2:0] wbd, input logic fl,
                      input logic iss, input logic stl, input logic busy,
                      input logic [1:0] st, input logic [15:0] sc);
    @(posedge clk);
    #1;
    drive(v, src, dst, us, ud, rw, mu, wbw, wbd, fl);
    expect_out(nm, iss, stl, busy, st, sc);
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    //    name          v src dst us ud rw mu wbw wbd fl  iss stl busy st sc
    step("reset_idle",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    step("idle",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    step("wr_r3",       1, 0, 3, 0, 0, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0);
    step("raw_r3",      1, 3, 0, 1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0);
    step("raw_r3_wb",   1, 3, 0, 1, 0, 0, 0, 1, 3, 0,  0, 1, 0, 1, 1);
    step("raw_r3_go",   1, 3, 0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 2);
    step("r3_clear",    1, 3, 0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 2);
    step("wr_r5_a",     1, 0, 5, 0, 0, 1, 0, 0, 0, 0,  1, 0, 0, 0, 2);
    step("wr_r5_b",     1, 0, 5, 0, 0, 1, 0, 0, 0, 0,  1, 0, 0, 0, 2);
    step("wr_r5_c",     1, 0, 5, 0, 0, 1, 0, 0, 0, 0,  1, 0, 0, 0, 2);
    step("wr_r5_full",  1, 0, 5, 0, 0, 1, 0, 0, 0, 0,  0, 1, 0, 0, 2);
    step("wr_r5_wb",    1, 0, 5, 0, 0, 1, 0, 1, 5, 0,  0, 1, 0, 1, 3);
    step("wr_r5_go",    1, 0, 5, 0, 0, 1, 0, 0, 0, 0,  1, 0, 0, 1, 4);
    step("multi",       1, 0, 1, 0, 0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 4);
    step("busy_1",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 4);
    step("busy_2",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 2, 5);
    step("busy_done",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 2, 6);
    step("wr_r4",       1, 0, 4, 0, 0, 1, 0, 0, 0, 0,  1, 0, 0, 0, 6);
    step("raw_r4",      1, 4, 0, 1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 6);
    step("flush_raw",   1, 4, 0, 1, 0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 7);
    step("post_flush",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 3, 7);
    step("r4_still",    1, 4, 0, 1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 7);
    step("r4_wb",       1, 4, 0, 1, 0, 0, 0, 1, 4, 0,  0, 1, 0, 1, 8);
    step("r4_go",       1, 4, 0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 9);
    step("flush_wr_r6", 1, 0, 6, 0, 0, 1, 0, 0, 0, 1,  0, 0, 0, 0, 9);
    step("r6_free",     1, 6, 0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 3, 9);
    step("wr_r2",       1, 0, 2, 0, 0, 1, 0, 0, 0, 0,  1, 0, 0, 0, 9);
    step("wr_r2_wb",    1, 0, 2, 0, 0, 1, 0, 1, 2, 0,  1, 0, 0, 0, 9);
    step("raw_r2",      1, 2, 0, 1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 9);
    step("raw_r2_wb",   1, 2, 0, 1, 0, 0, 0, 1, 2, 0,  0, 1, 0, 1, 10);
    step("raw_r2_go",   1, 2, 0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 11);
    step("wb_r6_idle",  0, 0, 0, 0, 0, 0, 0, 1, 6, 0,  0, 0, 0, 0, 11);
    step("r6_no_under", 1, 6, 0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 11);
    step("use_dst_r5",  1, 0, 5, 0, 1, 0, 0, 0, 0, 0,  0, 1, 0, 0, 11);
    step("multi_2",     1, 0, 0, 0, 0, 0, 1, 0, 0, 0,  1, 0, 0, 1, 12);
    step("raw_and_busy",1, 5, 0, 1, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 12);
    step("busy_tail",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 13);
    step("busy_over",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 13);
    step("raw_r5_pre",  1, 5, 0, 1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 13);
    // Reset asserted mid-stall clears the scoreboard immediately.
    @(posedge clk);
    #1;
    drive(1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
    #1 rst = 1'b0;
    expect_out("rst_mid", 1, 0, 0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    drive(1, 5, 0, 1, 0, 0, 0, 1, 5, 0);
    expect_out("late_wb_r5", 1, 0, 0, 0, 0);
    step("r5_after_rst",1, 5, 0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending actual=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_scheduler.md
Name: hazard_scheduler

Overview:
- Scoreboard-based stall/flush controller for the decode stage.
- Tracks in-flight register writes between decode issue and writeback, and EX occupancy by multi-cycle ops.
- Decides each cycle whether the decoded instruction issues into the D/E buffer. Otherwise it freezes PC and the F/D buffer and injects a bubble.
- Sits beside the decode stage; its enables drive the F/D and D/E buffer controls.

Parameters:
- N, 3, register address width (register file has 2**N registers).
- CNT_W, 2, width of each per-register pending-write counter.
- MUL_CYC, 3, EX occupancy in cycles of a multi-cycle op (must be ≥1).
- SC_W, 16, width of the stall-cycle performance counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- d_valid  in  1  decode stage holds a valid instruction.
- d_src  in  N  source register address.
- d_dst  in  N  destination register address.
- d_use_src  in  1  instruction reads d_src.
- d_use_dst  in  1  instruction reads d_dst as an operand.
- d_reg_write  in  1  instruction writes d_dst at writeback.
- d_multi  in  1  instruction occupies EX for MUL_CYC cycles.
- wb_reg_write  in  1  writeback commits this cycle.
- wb_dst  in  N  writeback destination.
- ex_flush  in  1  taken branch/redirect resolved in EX.
- pc_en  out  1  PC update enable.
- fd_en  out  1  F/D buffer load enable.
- fd_flush  out  1  clear F/D buffer to NOP.
- de_bubble  out  1  load NOP (all control zero) into D/E instead of decode outputs.
- issue  out  1  decode instruction enters D/E this cycle.
- stall  out  1  valid instruction held in decode.
- ex_busy  out  1  EX occupied by a multi-cycle op.
- state  out  2  registered scheduler state: 0 RUN, 1 RAW, 2 BUSY, 3 FLUSH.
- stall_cycles  out  SC_W  saturating count of cycles with stall=1.

Behaviour:
- Reset (rst=0, async):
  - All pend[r]=0, busy_cnt=0, state=RUN, stall_cycles=0.
  - With d_valid=0 the outputs are: pc_en=1, fd_en=1, fd_flush=0, de_bubble=1, issue=0, stall=0, ex_busy=0.
- Hazard terms, combinational from registered counters; no same-cycle WB bypass:
  - raw = d_valid & ((d_use_src & pend[d_src]!=0) | (d_use_dst & pend[d_dst]!=0) | (d_reg_write & pend[d_dst]=={CNT_W{1}})). The last term blocks counter overflow.
  - ex_busy = busy_cnt!=0.
- Issue and pipeline controls:
  - issue = d_valid & ~raw & ~ex_busy & ~ex_flush.
  - stall = d_valid & ~issue & ~ex_flush.
  - pc_en = fd_en = ~stall.
  - fd_flush = ex_flush.
  - de_bubble = ~issue.
- Scoreboard update at each clock edge, per register r:
  - inc = issue & d_reg_write & (d_dst==r).
  - dec = wb_reg_write & (wb_dst==r) & (pend[r]!=0).
  - inc&dec: unchanged. inc only: +1. dec only: −1.
  - WB to a register with pend=0 is ignored (no underflow).
  - Result: a RAW-stalled instruction issues the cycle after its producer's WB.
- EX occupancy:
  - If issue & d_multi: busy_cnt ← MUL_CYC−1.
  - Else if busy_cnt!=0: busy_cnt decrements.
  - With MUL_CYC=1 no stall results. ex_flush does not alter busy_cnt.
- State register, next-state priority:
  - FLUSH if ex_flush.
  - Else RAW if d_valid&raw.
  - Else BUSY if d_valid&ex_busy.
  - Else RUN.
  - State is informational only; no output depends on it.
- stall_cycles: increments when stall=1; holds at all-ones.
- Flush: the decode instruction is discarded. No issue, no scoreboard increment, bubble into D/E, F/D cleared, PC free to redirect. Flush takes priority over raw/busy.
- Simultaneous raw and ex_busy: stall. state=RAW.
- Reset asserted mid-stall: counters cleared immediately. Pending writebacks arriving after reset release are ignored by the underflow guard.

Test Plan:
- Reset, then d_valid=0 → pc_en=1, de_bubble=1, issue=0, state=0, stall_cycles=0.
- Issue d_dst=3 with write; next cycle d_src=3, use_src=1 → stall=1, fd_en=0, de_bubble=1, state=1. Pulse WB dst=3 → issue=1 on the following cycle, pend[3]=0.
- Two back-to-back writes to r5 → pend[5]=2. Third writer to r5 issues. A fourth writer (pend=3) stalls until a WB to r5.
- d_multi issue with MUL_CYC=3 → ex_busy=1 for 2 cycles. An independent next instruction stalls for 2 cycles, state=2, stall_cycles=2.
- ex_flush during a RAW stall → fd_flush=1, stall=0, issue=0, pend unchanged, state=3 next cycle.
- Same-cycle issue of a write to r2 and WB to r2 with pend[2]=1 → pend[2] stays 1. WB to r6 with pend=0 → pend[6] stays 0.
